pulse_timestamper: RTL
======================

Name: pulse_timestamper

Overview:
Synthesizable consumer of the delay card's test-pulse stream: takes an asynchronous pulse input, synchronizes it and detects rising edges. Each accepted edge is stamped with a coarse-cycle/seconds counter pair and queued in a FIFO for readout. Sits directly downstream of the bench random-pulse source and upstream of the readout/compare logic. Enforces a programmable dead time and counts lost pulses.

Parameters:
g_coarse_range, 125000000, cycles per seconds tick; coarse counter counts 0..g_coarse_range-1
g_coarse_width, 28, coarse field width; must satisfy 2**g_coarse_width >= g_coarse_range
g_seconds_width, 32, seconds field width, wraps modulo 2**g_seconds_width
g_fifo_depth, 16, timestamp FIFO entries, power of two, >= 2
g_dead_time, 8, minimum cycles between accepted edges, >= 1

Ports:
clk_sys_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
pulse_i  in  1  asynchronous pulse input
enable_i  in  1  edge acceptance enable, synchronous to clk_sys_i
ts_coarse_o  out  g_coarse_width  head-of-FIFO coarse stamp
ts_seconds_o  out  g_seconds_width  head-of-FIFO seconds stamp
ts_valid_o  out  1  FIFO not empty; head data valid
ts_ready_i  in  1  consumer pop; entry popped on a cycle where valid and ready are both high
overflow_cnt_o  out  16  edges lost because the FIFO was full; saturates at 16'hFFFF
fifo_count_o  out  $clog2(g_fifo_depth)+1  current occupancy

Behaviour:
- Reset (async assert, sync deassert inside the block): all outputs 0, counters 0, FIFO empty, sync chain 0, dead-time counter 0.
- Sync: 3-flop chain s1->s2->s3. Edge strobe = s2 & ~s3. When pulse_i is first sampled high at clock k, the strobe is active in cycle k+2.
- Time base: coarse increments every cycle. At g_coarse_range-1 it wraps to 0 and seconds increments in the same cycle. Both fields are registered together, so a captured pair is always consistent. Capture on the wrap cycle yields coarse=0 with the new seconds value.
- Stamp = {seconds, coarse} at the strobe cycle. Raw value, no sync-delay compensation (fixed 2-cycle offset, handled in software).
- Acceptance: strobe accepted iff enable_i=1 and dead-time counter = 0.
  - On acceptance, the dead-time counter loads g_dead_time-1 and decrements to 0.
  - Strobes arriving while the counter is non-zero are dropped silently and not counted as overflow.
  - Strobes with enable_i=0 are ignored and do not load the dead-time counter.
- FIFO write: an accepted strobe writes at the end of the strobe cycle.
  - If the FIFO is full and no pop occurs that cycle, the entry is dropped and overflow_cnt_o increments (saturating).
  - Full with a simultaneous pop: write is accepted and occupancy is unchanged.
  - Empty with write: ts_valid_o rises the next cycle. Total latency from first sampling at k to valid is k+3.
  - Empty with simultaneous write and no pop: no fall-through.
- Read: ts_*_o are registered head-of-FIFO values (first-word-fall-through from the registered RAM output). A pop advances the head next cycle. ts_valid_o drops the cycle after the last entry is popped unless a write occurred.
- enable_i deassert mid-stream: FIFO contents, time base and overflow count are retained; only acceptance stops.
- Reset mid-operation: FIFO flushed, time base restarted at 0/0, in-flight strobe discarded.
- Pointers: $clog2(g_fifo_depth)+1 bits with the MSB used for wrap. Full = MSBs differ and rest equal.

Decomposition:
- Package fd_tstamp_pkg:
  - typedef t_timestamp struct {seconds [g_seconds_width], coarse [g_coarse_width]}
  - c_OVF_CNT_WIDTH = 16
  - function f_log2_ceil
- Sub-module gen_sync_fifo: one-clock FIFO of t_timestamp with FWFT, full/empty/count, and simultaneous read/write on full allowed. The top level holds the sync chain, time base, dead-time logic and overflow counter.

Test Plan:
1. Reset, then a single 30 ns pulse (8 ns clk) at coarse=100 -> after 3 cycles ts_valid_o=1, stamp coarse=102, seconds=0; pop -> valid=0, count=0.
2. g_coarse_range=1000: pulse whose strobe lands on the wrap cycle -> stamp coarse=0, seconds=1. Strobe one cycle earlier -> coarse=999, seconds=0.
3. g_dead_time=8: pulses with strobes 5 cycles apart -> second dropped, 1 entry, overflow_cnt_o=0. Strobes 8 apart -> 2 entries.
4. g_fifo_depth=4, no pops, 6 spaced pulses -> count=4, overflow_cnt_o=2, FIFO holds first 4 stamps in order.
5. FIFO full, ts_ready_i=1 in the cycle of a new strobe -> write accepted, count stays 4, overflow unchanged, oldest entry removed.
6. enable_i=0 during 3 pulses -> no entries. Then rst_n_i pulse with 2 entries queued -> valid=0, count=0, overflow=0, coarse restarts at 0.

Source files
------------

// File: rtl/pulse_timestamper_pkg.sv
// rtl/pulse_timestamper_pkg.sv - shared types, widths and helpers for the pulse timestamper
// Purpose: timestamp record layout, overflow counter width and a ceil-log2 helper.
package fd_tstamp_pkg;

    localparam int c_COARSE_WIDTH  = 28;
    localparam int c_SECONDS_WIDTH = 32;
    localparam int c_OVF_CNT_WIDTH = 16;

    // Seconds sit in the upper bits so a packed stamp orders naturally by time.
    typedef struct packed {
        logic [c_SECONDS_WIDTH-1:0] seconds;
        logic [c_COARSE_WIDTH-1:0]  coarse;
    } t_timestamp;

    function automatic int f_log2_ceil(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pulse_timestamper_if.sv
// rtl/pulse_timestamper_if.sv - timestamp readout handshake bundle
// Purpose: carries the head-of-FIFO stamp and its valid/ready pop handshake.
// Ports:
//   ts_coarse_o   head-of-FIFO coarse stamp (source -> consumer)
//   ts_seconds_o  head-of-FIFO seconds stamp (source -> consumer)
//   ts_valid_o    head data valid (source -> consumer)
//   ts_ready_i    consumer pop request (consumer -> source)
interface pulse_timestamper_if #(
    parameter int g_coarse_width  = 28,
    parameter int g_seconds_width = 32
);

    logic [g_coarse_width-1:0]  ts_coarse_o;
    logic [g_seconds_width-1:0] ts_seconds_o;
    logic                       ts_valid_o;
    logic                       ts_ready_i;

    modport master (
        output ts_coarse_o,
        output ts_seconds_o,
        output ts_valid_o,
        input  ts_ready_i
    );

    modport slave (
        input  ts_coarse_o,
        input  ts_seconds_o,
        input  ts_valid_o,
        output ts_ready_i
    );

endinterface

// File: rtl/pulse_timestamper_fifo.sv
// rtl/pulse_timestamper_fifo.sv - single-clock first-word-fall-through timestamp FIFO
// Purpose: stores stamps, presents a registered head entry, allows write-on-full
//          when the same cycle pops.
// Ports:
//   clk_i, rst_n_i  clock and asynchronous active-low reset
//   wr_data_i/wr_en_i  write side; wr_drop_o flags a write lost to a full FIFO
//   rd_data_o/rd_valid_o/rd_en_i  registered head entry and pop strobe
//   count_o  occupancy including the head entry
module gen_sync_fifo
    import fd_tstamp_pkg::*;
#(
    parameter int g_width = 60,
    parameter int g_depth = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [g_width-1:0]            wr_data_i,
    input  logic                          wr_en_i,
    input  logic                          rd_en_i,
    output logic [g_width-1:0]            rd_data_o,
    output logic                          rd_valid_o,
    output logic                          wr_drop_o,
    output logic [f_log2_ceil(g_depth):0] count_o
);

    localparam int c_AW = f_log2_ceil(g_depth);

    logic [g_width-1:0] mem [g_depth];
    logic [c_AW:0]      wr_ptr;
    logic [c_AW:0]      rd_ptr;
    logic [c_AW:0]      rd_ptr_nxt;
    logic [c_AW:0]      remain;
    logic               full;
    logic               pop;
    logic               push;

    assign full       = (wr_ptr[c_AW] != rd_ptr[c_AW]) &&
                        (wr_ptr[c_AW-1:0] == rd_ptr[c_AW-1:0]);
    assign pop        = rd_valid_o & rd_en_i;
    assign push       = wr_en_i & (~full | pop);
    assign wr_drop_o  = wr_en_i & full & ~pop;
    assign count_o    = wr_ptr - rd_ptr;
    assign rd_ptr_nxt = rd_ptr + {{c_AW{1'b0}}, pop};
    // Entries that existed before this edge and survive the pop; a write landing
    // this edge is deliberately excluded so an empty FIFO never falls through.
    assign remain     = wr_ptr - rd_ptr_nxt;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[c_AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + {{c_AW{1'b0}}, push};
            rd_ptr     <= rd_ptr_nxt;
            rd_valid_o <= (remain != '0) || (push && pop);
            if (remain != '0) begin
                rd_data_o <= mem[rd_ptr_nxt[c_AW-1:0]];
            end else if (push && pop) begin
                // Popping the last entry while writing: the new stamp becomes head.
                rd_data_o <= wr_data_i;
            end
        end
    end

endmodule

// File: rtl/pulse_timestamper.sv
// rtl/pulse_timestamper.sv - test-pulse edge timestamper with dead time and overflow count
// Purpose: synchronizes pulse_i, stamps accepted rising edges with {seconds, coarse}
//          and queues them for readout.
// Ports:
//   clk_sys_i, rst_n_i  system clock, asynchronous active-low reset
//   pulse_i             asynchronous pulse input
//   enable_i            edge acceptance enable
//   ts_bus              head-of-FIFO stamp with valid/ready pop handshake
//   overflow_cnt_o      saturating count of edges lost to a full FIFO
//   fifo_count_o        current FIFO occupancy
module pulse_timestamper
    import fd_tstamp_pkg::*;
#(
    parameter int g_coarse_range  = 125000000,
    parameter int g_coarse_width  = 28,
    parameter int g_seconds_width = 32,
    parameter int g_fifo_depth    = 16,
    parameter int g_dead_time     = 8
) (
    input  logic                          clk_sys_i,
    input  logic                          rst_n_i,
    input  logic                          pulse_i,
    input  logic                          enable_i,
    pulse_timestamper_if.master           ts_bus,
    output logic [c_OVF_CNT_WIDTH-1:0]    overflow_cnt_o,
    output logic [$clog2(g_fifo_depth):0] fifo_count_o
);

    localparam int c_TS_WIDTH = g_seconds_width + g_coarse_width;
    localparam int c_DW       = f_log2_ceil(g_dead_time) + 1;
    localparam logic [g_coarse_width-1:0] c_COARSE_LAST = g_coarse_width'(g_coarse_range - 1);
    localparam logic [c_DW-1:0]           c_DEAD_LOAD   = c_DW'(g_dead_time - 1);

    logic [1:0]                 rst_sync;
    logic                       rst_n;
    logic [2:0]                 sync;
    logic                       strobe;
    logic                       accept;
    logic [c_DW-1:0]            dead_cnt;
    logic [g_coarse_width-1:0]  coarse;
    logic [g_seconds_width-1:0] seconds;
    logic                       wr_drop;
    logic [c_TS_WIDTH-1:0]      head;

    // Reset asserts immediately, releases two clocks after rst_n_i rises.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    always_ff @(posedge clk_sys_i or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], pulse_i};
        end
    end
    assign strobe = sync[1] & ~sync[2];

    // Coarse and seconds update on the same edge so any captured pair is coherent.
    always_ff @(posedge clk_sys_i or negedge rst_n) begin
        if (!rst_n) begin
            coarse  <= '0;
            seconds <= '0;
        end else if (coarse == c_COARSE_LAST) begin
            coarse  <= '0;
            seconds <= seconds + g_seconds_width'(1);
        end else begin
            coarse  <= coarse + g_coarse_width'(1);
        end
    end

    assign accept = strobe & enable_i & (dead_cnt == '0);

    always_ff @(posedge clk_sys_i or negedge rst_n) begin
        if (!rst_n) begin
            dead_cnt <= '0;
        end else if (accept) begin
            dead_cnt <= c_DEAD_LOAD;
        end else if (dead_cnt != '0) begin
            dead_cnt <= dead_cnt - c_DW'(1);
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_n) begin
        if (!rst_n) begin
            overflow_cnt_o <= '0;
        end else if (wr_drop && (overflow_cnt_o != '1)) begin
            overflow_cnt_o <= overflow_cnt_o + c_OVF_CNT_WIDTH'(1);
        end
    end

    gen_sync_fifo #(
        .g_width (c_TS_WIDTH),
        .g_depth (g_fifo_depth)
    ) u_fifo (
        .clk_i      (clk_sys_i),
        .rst_n_i    (rst_n),
        .wr_data_i  ({seconds, coarse}),
        .wr_en_i    (accept),
        .rd_en_i    (ts_bus.ts_ready_i),
        .rd_data_o  (head),
        .rd_valid_o (ts_bus.ts_valid_o),
        .wr_drop_o  (wr_drop),
        .count_o    (fifo_count_o)
    );

    assign ts_bus.ts_coarse_o  = head[g_coarse_width-1:0];
    assign ts_bus.ts_seconds_o = head[c_TS_WIDTH-1:g_coarse_width];

endmodule
